// File: rtl/ppu_palette.sv
// ppu_palette: palette RAM plus the two-stage pixel back end of the PPU.
// Stage 1 registers the renderer's index and coordinates. Stage 2 looks up
// the palette, applies greyscale and emphasis, and drives the encoder stream.
// CPU accesses to $3F00-$3FFF read and write the same 32x6 array.
module ppu_palette #(
  parameter bit BG_HACK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] palette_idx,
  input  logic       frame_on,
  input  logic       render_en,
  input  logic [8:0] y,
  input  logic [8:0] cycle,
  input  logic [13:0] vram_addr,
  input  logic [7:0] ppumask,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic [5:0] pix_color,
  output logic [2:0] pix_emph,
  output logic       pix_valid,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic       line_start,
  output logic       frame_start
);

  // $10/$14/$18/$1C alias the backdrop entries $00/$04/$08/$0C
  function automatic logic [4:0] eff(input logic [4:0] a);
    eff = (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
  endfunction

  logic [5:0] pal [32];

  logic       hit;
  logic [4:0] cpu_idx;
  logic [5:0] grey_mask;

  assign hit       = (vram_addr[13:8] == 6'h3F);
  assign cpu_idx   = eff(vram_addr[4:0]);
  assign grey_mask = ppumask[0] ? 6'h30 : 6'h3F;

  logic unused_ok;
  assign unused_ok = ^{cycle[8], cpu_din[7:6], ppumask[4:1], vram_addr[7:5]};

  logic [4:0] s1_idx;
  logic       s1_valid;
  logic [7:0] s1_x;
  logic [7:0] s1_y;
  logic       s1_line;
  logic       s1_frame;

  logic [4:0] s1_idx_nxt;
  logic       s1_line_nxt;

  // Stage-1 index source: renderer pixel, BG_HACK address, or backdrop
  always_comb begin
    s1_idx_nxt = 5'd0;
    if (frame_on) begin
      s1_idx_nxt = palette_idx;
    end else if (BG_HACK && !render_en && hit) begin
      s1_idx_nxt = vram_addr[4:0];
    end
    s1_line_nxt = frame_on && (cycle == 9'd1);
  end

  // Palette RAM: cleared by reset, written by CPU hits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        pal[i] <= 6'd0;
      end
    end else if (cpu_wr && hit) begin
      pal[cpu_idx] <= cpu_din[5:0];
    end
  end

  // CPU read port; reads the pre-write value when a write lands on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_dout <= 8'd0;
    end else if (cpu_rd && hit) begin
      cpu_dout <= {2'b00, pal[cpu_idx] & grey_mask};
    end
  end

  // Stage 1: capture renderer index and pixel coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_idx   <= 5'd0;
      s1_valid <= 1'b0;
      s1_x     <= 8'd0;
      s1_y     <= 8'd0;
      s1_line  <= 1'b0;
      s1_frame <= 1'b0;
    end else begin
      s1_idx   <= s1_idx_nxt;
      s1_valid <= frame_on;
      s1_x     <= cycle[7:0] - 8'd1;
      s1_y     <= y[7:0];
      s1_line  <= s1_line_nxt;
      s1_frame <= s1_line_nxt && (y == 9'd0);
    end
  end

  // Stage 2: palette lookup, greyscale/emphasis from the current ppumask
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_color   <= 6'd0;
      pix_emph    <= 3'd0;
      pix_valid   <= 1'b0;
      pix_x       <= 8'd0;
      pix_y       <= 8'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_color   <= pal[eff(s1_idx)] & grey_mask;
      pix_emph    <= ppumask[7:5];
      pix_valid   <= s1_valid;
      pix_x       <= s1_x;
      pix_y       <= s1_y;
      line_start  <= s1_line;
      frame_start <= s1_frame;
    end
  end

endmodule

// File: doc/ppu_palette.md
# ppu_palette

Pixel back end of the PPU, directly downstream of the background/sprite renderer. Holds the 32-entry palette RAM and services CPU reads/writes to $3F00-$3FFF. Converts the renderer's 5-bit palette index into a 6-bit NES colour plus emphasis bits, and emits a pixel stream with valid, x/y and frame/line markers for the video encoder.

## Interface

- `BG_HACK`, default 1: when 1 and rendering is disabled with `vram_addr` inside $3F00-$3FFF, output the entry addressed by `vram_addr` instead of entry 0.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `palette_idx` in 5: renderer pixel index; bit 4 selects the sprite palette.
- `frame_on` in 1: renderer pixel strobe, high for cycles 1..256 of visible lines.
- `render_en` in 1: background or sprite rendering enabled.
- `y` in 9: renderer scanline (0..239 visible, 511 = prerender).
- `cycle` in 9: renderer dot, 0..340.
- `vram_addr` in 14: current PPU v address.
- `ppumask` in 8: bit 0 = greyscale, bits 7:5 = emphasis.
- `cpu_wr` in 1: one-cycle $2007 write strobe.
- `cpu_rd` in 1: one-cycle $2007 read strobe.
- `cpu_din` in 8: write data; bits 5:0 are used.
- `cpu_dout` out 8: palette read data.
- `pix_color` out 6: NES master-palette colour.
- `pix_emph` out 3: emphasis bits.
- `pix_valid` out 1: output pixel qualifier.
- `pix_x` out 8, `pix_y` out 8: output pixel coordinates.
- `line_start` out 1: coincident with pixel x=0 of each line.
- `frame_start` out 1: coincident with pixel (0,0).

## Operation

- **Storage.** The palette is a 32x6 register array; reset clears all entries to 0.
- **Mirroring.** `eff(a) = (a[1:0]==0) ? {1'b0, a[3:0]} : a[4:0]`. It maps $10/$14/$18/$1C onto $00/$04/$08/$0C and applies to CPU writes, CPU reads and pixel lookups.
- **CPU hit.** `hit = vram_addr[13:8]==6'h3F`.
- **CPU write.** `cpu_wr & hit`: `pal[eff(vram_addr[4:0])] <= cpu_din[5:0]` at the next edge. `cpu_wr` without `hit` is ignored.
- **CPU read.** `cpu_rd & hit`: `cpu_dout <= {2'b00, pal[eff] & (ppumask[0] ? 6'h30 : 6'h3F)}`, registered. `cpu_dout` holds between reads. `cpu_rd` without `hit` leaves `cpu_dout` unchanged.
- **Stage 1** (registered every cycle):
  - `s1_idx` selection:
    - `frame_on`: `palette_idx`.
    - `!render_en & hit & BG_HACK`: `vram_addr[4:0]`.
    - otherwise: 0.
  - `s1_valid = frame_on`.
  - `s1_x = cycle[7:0] - 1`, with 8-bit wrap (cycle 1 gives 0, cycle 256 gives 255).
  - `s1_y = y[7:0]`.
  - `s1_line = frame_on & cycle==1`.
  - `s1_frame = s1_line & y==0`.
- **Stage 2** (registered):
  - `pix_color = pal[eff(s1_idx)] & (ppumask[0] ? 6'h30 : 6'h3F)`.
  - `pix_emph = ppumask[7:5]`.
  - `pix_valid`, `pix_x`, `pix_y`, `line_start`, `frame_start` take the stage-1 values.
  - `ppumask` is sampled in stage 2, not stage 1.
- **Pixels outside the visible area.** While `pix_valid=0`, `pix_color` still carries the backdrop (or BG_HACK) colour; the encoder uses it for the border.
- **No backpressure.** The block streams one pixel per `clk` while `frame_on` is high.

## Timing

- **Reset values.** On `rst` at an edge, all outputs are 0 the following cycle, pipeline registers are 0, and the RAM is 0. `rst` asserted mid-line drops `pix_valid` after that edge; no partial marker pulses follow.
- **Pixel latency.** 2 clocks from `frame_on`/`palette_idx` to `pix_*`. The first `pix_valid` of a line appears 2 clocks after `cycle==1`.
- **CPU read latency.** 1 clock from `cpu_rd` to `cpu_dout`.
- **Write vs pixel lookup, same entry, same cycle.** Stage 2 registers the pre-write value. The new value is visible to stage 2 from the next cycle.
- **Write and read, same cycle.** `cpu_wr` and `cpu_rd` together: the read returns the pre-write value.
- **Markers.** `line_start` and `frame_start` are single-cycle pulses, exactly aligned with the qualifying `pix_valid` cycle.
- **Prerender line.** `y=511` is never `frame_on`, so no pixels are emitted for it.

## Test plan

- **Reset.** Reset, then idle with `frame_on=0`, `render_en=1` -> all outputs 0 and `pix_color=0`.
- **Write and mirroring.** Write $3F10=0x2A.
  - Read $3F00 -> `cpu_dout=0x2A`.
  - Read $3F14 -> it returns the $3F04 contents.
  - `palette_idx=5'h10` -> `pix_color=0x2A`.
- **One visible line.** Drive `y=0`, `cycle` 0..340, `frame_on` high for cycles 1..256, `palette_idx=cycle[4:0]`.
  - Expect 256 `pix_valid` pixels with x 0..255, each delayed 2 clocks.
  - `line_start` and `frame_start` fire on x=0 only.
- **Greyscale and emphasis.** Set `pal[3]=0x1C`, `ppumask=0xE1` -> `pix_color=0x10`, `pix_emph=3'b111`, `cpu_dout` for $3F03 = 0x10.
- **BG hack.** `render_en=0`, `vram_addr=14'h3F07`, `pal[7]=0x16` -> `pix_color=0x16`. With `vram_addr=14'h2000` -> `pix_color=pal[0]`.
- **Same-cycle write and lookup.** `pal[1]=0x01`. Write $3F01=0x30 on the cycle stage 1 holds index 1 -> that pixel shows 0x01 and the next pixel with index 1 shows 0x30. Assert `rst` mid-line -> `pix_valid=0` on the next cycle.
